// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock,
// through a registered carry, with a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder: DIGIT must divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] digit_sum;
    logic             digit_cout;
    logic             digit_msb_cin;
    logic             c;

    // Ripple across the low DIGIT bits; keep the carry into the digit's top bit for overflow.
    always_comb begin
        c             = carry_q;
        digit_msb_cin = carry_q;
        digit_sum     = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            digit_msb_cin = c;
            digit_sum[i]  = a_q[i] ^ b_q[i] ^ c;
            c             = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        digit_cout = c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // Result digits enter at the MSB so the LSB digit lands at bit 0 after STEPS shifts.
                sum_d   = WIDTH'({digit_sum, sum_q} >> DIGIT);
                carry_d = digit_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    cout_d  = digit_cout;
                    ovf_d   = digit_cout ^ digit_msb_cin;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance
// checked against plain a+b+cin arithmetic.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_add8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_add16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision sum, carry out is bit n, overflow when like-signed operands give an unlike-signed result.
    function automatic void model(input logic [63:0] x, input logic [63:0] y, input logic c, input int n,
                                  output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] full;
        logic [63:0] mask;
        full = x + y + 64'(c);
        mask = (64'd1 << n) - 64'd1;
        s    = full & mask;
        co   = full[n];
        ov   = (x[n-1] == y[n-1]) && (s[n-1] != x[n-1]);
    endfunction

    task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                       input int inject, input int watch, input string tag);
        logic [63:0] es;
        logic        ec, eo;
        int          nb, nd;
        bit          seen;
        model(64'(xa), 64'(xb), xc, 8, es, ec, eo);
        a8 = xa; b8 = xb; cin8 = xc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) seen = 1'b1;
            else begin
                if (busy8) nb++;
                start8 = (nb == inject);
                if (start8) begin a8 = 8'h11; b8 = 8'h22; end
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_cycles"}, 64'(nb), 64'd8);
        check({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
        check({tag, "_sum"}, 64'(sum8), es);
        check({tag, "_cout"}, 64'(cout8), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf8), 64'(eo));
        nd = 0;
        for (int i = 0; i < watch; i++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check({tag, "_extra_done"}, 64'(nd), 64'd0);
        check({tag, "_sum_held"}, 64'(sum8), es);
    endtask

    task automatic op16(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input string tag);
        logic [63:0] es;
        logic        ec, eo;
        int          nb;
        bit          seen;
        model(64'(xa), 64'(xb), xc, 16, es, ec, eo);
        a16 = xa; b16 = xb; cin16 = xc; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done16) seen = 1'b1;
            else begin
                if (busy16) nb++;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_cycles"}, 64'(nb), 64'd4);
        check({tag, "_sum"}, 64'(sum16), es);
        check({tag, "_cout"}, 64'(cout16), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf16), 64'(eo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done16), 64'd0);
    endtask

    task automatic back_to_back();
        logic [7:0]  qa[4];
        logic [7:0]  qb[4];
        logic        qc[4];
        logic [63:0] es;
        logic        ec, eo;
        int          cnt;
        qa = '{8'h12, 8'hF0, 8'h7F, 8'h80};
        qb = '{8'h34, 8'h20, 8'h7F, 8'hFF};
        qc = '{1'b0, 1'b1, 1'b1, 1'b0};
        a8 = qa[0]; b8 = qb[0]; cin8 = qc[0]; start8 = 1'b1;
        @(negedge clk);
        a8 = qa[1]; b8 = qb[1]; cin8 = qc[1];
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (!done8 && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            model(64'(qa[k]), 64'(qb[k]), qc[k], 8, es, ec, eo);
            check($sformatf("b2b%0d_period", k), 64'(cnt), 64'd8);
            check($sformatf("b2b%0d_sum", k), 64'(sum8), es);
            check($sformatf("b2b%0d_cout", k), 64'(cout8), 64'(ec));
            check($sformatf("b2b%0d_ovf", k), 64'(ovf8), 64'(eo));
            if (k == 3) start8 = 1'b0;
            @(negedge clk);
            if (k < 3) check($sformatf("b2b%0d_rebusy", k), 64'(busy8), 64'd1);
            if (k < 2) begin a8 = qa[k+2]; b8 = qb[k+2]; cin8 = qc[k+2]; end
        end
        check("b2b_idle_busy", 64'(busy8), 64'd0);
        check("b2b_idle_done", 64'(done8), 64'd0);
    endtask

    initial begin
        int nd;
        repeat (2) @(negedge clk);
        start8 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_sum", 64'(sum8), 64'd0);
        check("rst_cout", 64'(cout8), 64'd0);
        check("rst_ovf", 64'(ovf8), 64'd0);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_sum16", 64'(sum16), 64'd0);

        op8(8'hFF, 8'h01, 1'b0, -1, 2, "ff_plus_1");
        op8(8'h35, 8'h4A, 1'b1, -1, 2, "h35_h4a_c1");
        op8(8'h7F, 8'h01, 1'b0, -1, 2, "h7f_h01");
        op8(8'h80, 8'h80, 1'b0, -1, 2, "h80_h80");
        op8(8'h01, 8'h01, 1'b0, 3, 12, "ignore_start");
        for (int i = 0; i < 30; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), -1, 1, $sformatf("rnd8_%0d", i));

        back_to_back();

        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_sum", 64'(sum8), 64'd0);
        check("abort_cout", 64'(cout8), 64'd0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        op8(8'h10, 8'h20, 1'b0, -1, 2, "post_rst");

        op16(16'hFFFF, 16'h0001, 1'b0, "w16_ffff_1");
        op16(16'h7FFF, 16'h0001, 1'b0, "w16_7fff_1");
        for (int i = 0; i < 200; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd16_%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
